// File: rtl/ntt_arbiter_pkg.sv
// Shared KEM types used around the NTT wrapper and its arbiter.
// Defines the polynomial word, the NTT operation mode and the requester count.
package TYPES_KEM;

  localparam int KYBER_N = 256;
  localparam int COEF_W = 12;
  localparam int NTT_ARB_N_REQ = 3;

  typedef logic [KYBER_N-1:0][COEF_W-1:0] poly_t;

  typedef enum logic [1:0] {
    NTT_a  = 2'd0,
    INTT_a = 2'd1,
    PWM_ab = 2'd2,
    ADD_ab = 2'd3
  } ntt_mode_t;

  // Modes the shared wrapper can actually execute
  function automatic logic ntt_arb_mode_ok(input ntt_mode_t m);
    return (m == NTT_a) || (m == PWM_ab);
  endfunction

endpackage

// File: rtl/ntt_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last, wrapping.
// Reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   j;

  always_comb begin
    found   = 1'b0;
    j       = 0;
    valid_o = 1'b0;
    gnt_o   = '0;
    idx_o   = '0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ntt_arbiter.sv
// Round-robin arbiter sharing one NTT_wrapper among N_REQ sequencers.
// Optional BUSY watchdog enabled by defining NTT_ARB_TIMEOUT_EN.
module ntt_arbiter
  import TYPES_KEM::*;
#(
  parameter int N_REQ       = NTT_ARB_N_REQ,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  ntt_mode_t        mode_i [N_REQ],
  input  poly_t            poly_a_i [N_REQ],
  input  poly_t            poly_b_i [N_REQ],
  output logic [N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0] done_o,
  output logic             err_o,
  output poly_t            poly_c_o,
  output logic             ntt_run_o,
  output ntt_mode_t        ntt_mode_o,
  output poly_t            ntt_poly_a_o,
  output poly_t            ntt_poly_b_o,
  input  poly_t            ntt_poly_c_i,
  input  logic             ntt_done_i
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
    $error("ntt_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_bad_to
    $error("ntt_arbiter: TIMEOUT_CYC must fit 13 bits");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             run_q, run_d;
  ntt_mode_t        mode_q, mode_d;
  poly_t            pa_q, pa_d;
  poly_t            pb_q, pb_d;
  poly_t            pc_q, pc_d;

`ifdef NTT_ARB_TIMEOUT_EN
  localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYC - 1);
  logic [12:0] cnt_q, cnt_d;
`endif

  logic             pick_vld;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pick_vld),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = 1'b0;
    run_d   = 1'b0;
    mode_d  = mode_q;
    pa_d    = pa_q;
    pb_d    = pb_q;
    pc_d    = pc_q;
`ifdef NTT_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d  = pick_idx;
          gnt_d  = pick_gnt;
          mode_d = mode_i[pick_idx];
          pa_d   = poly_a_i[pick_idx];
          pb_d   = poly_b_i[pick_idx];
          pc_d   = '0;
          if (ntt_arb_mode_ok(mode_i[pick_idx])) begin
            run_d   = 1'b1;
            state_d = LAUNCH;
          end else begin
            state_d = RESP;
          end
        end
      end
      LAUNCH: begin
        state_d = BUSY;
`ifdef NTT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
`ifdef NTT_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 13'd1;
`endif
        if (ntt_done_i) begin
          pc_d    = ntt_poly_c_i;
          done_d  = gnt_q;
          state_d = RESP;
        end
`ifdef NTT_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          pc_d    = '0;
          done_d  = gnt_q;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        // Rejected modes arrive with no pulse pending; issue it now
        if (done_q == '0) begin
          done_d = gnt_q;
          err_d  = 1'b1;
        end else begin
          gnt_d   = '0;
          last_d  = idx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      mode_q  <= NTT_a;
      pa_q    <= '0;
      pb_q    <= '0;
      pc_q    <= '0;
`ifdef NTT_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      run_q   <= run_d;
      mode_q  <= mode_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pc_q    <= pc_d;
`ifdef NTT_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign poly_c_o     = pc_q;
  assign ntt_run_o    = run_q;
  assign ntt_mode_o   = mode_q;
  assign ntt_poly_a_o = pa_q;
  assign ntt_poly_b_o = pb_q;

endmodule

// File: tb/tb_ntt_arbiter.sv
// Directed bench for ntt_arbiter with a latency-programmable wrapper model.
// Timeout case runs only when NTT_ARB_TIMEOUT_EN is defined.
module tb_ntt_arbiter;
  import TYPES_KEM::*;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] req_i;
  ntt_mode_t    mode_i [N];
  poly_t        poly_a_i [N];
  poly_t        poly_b_i [N];
  logic [N-1:0] gnt_o, done_o;
  logic         err_o, ntt_run_o, ntt_done_i;
  poly_t        poly_c_o, ntt_poly_a_o, ntt_poly_b_o, ntt_poly_c_i;
  ntt_mode_t    ntt_mode_o;

  int total = 0;
  int bad = 0;
  int lat = 20;
  bit hang = 1'b0;
  bit spur = 1'b0;
  int run_cnt = 0;
  int hot_bad = 0;

  ntt_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .mode_i       (mode_i),
    .poly_a_i     (poly_a_i),
    .poly_b_i     (poly_b_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .poly_c_o     (poly_c_o),
    .ntt_run_o    (ntt_run_o),
    .ntt_mode_o   (ntt_mode_o),
    .ntt_poly_a_o (ntt_poly_a_o),
    .ntt_poly_b_o (ntt_poly_b_o),
    .ntt_poly_c_i (ntt_poly_c_i),
    .ntt_done_i   (ntt_done_i)
  );

  always #5 clk = ~clk;

  function automatic poly_t mkpoly(input int seed);
    poly_t p;
    for (int k = 0; k < KYBER_N; k++)
      p[k] = 12'((seed * 97 + k * 13 + 5) & 12'hFFF);
    return p;
  endfunction

  function automatic poly_t wr_model(input ntt_mode_t m, input poly_t a, input poly_t b);
    poly_t c;
    c = '0;
    for (int k = 0; k < KYBER_N; k++) begin
      if (m == NTT_a) c[k] = a[KYBER_N-1-k] + 12'd1;
      else if (m == PWM_ab) c[k] = a[k] + b[k];
    end
    return c;
  endfunction

  function automatic logic [31:0] fold(input poly_t p);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < KYBER_N; k++)
      acc = acc + 32'(p[k]) * 32'(k + 1);
    return acc;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string tag, input int budget, output int n);
    n = 0;
    while (!ntt_run_o && n < budget) begin
      step();
      n++;
    end
    check(tag, ntt_run_o, 1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (done_o == '0 && n < budget) begin
      step();
      n++;
    end
    check(tag, |done_o, 1);
  endtask

  always @(negedge clk) begin
    if (ntt_run_o) run_cnt++;
    if (!$onehot0(gnt_o)) hot_bad++;
    if ((done_o & ~gnt_o) != '0) hot_bad++;
  end

  // NTT_wrapper stand-in: done pulse lat cycles after run
  initial begin
    bit        busy;
    int        cnt;
    ntt_mode_t m;
    poly_t     a, b;
    busy = 1'b0;
    cnt = 0;
    m = NTT_a;
    a = '0;
    b = '0;
    ntt_done_i = 1'b0;
    ntt_poly_c_i = '0;
    forever begin
      @(negedge clk);
      ntt_done_i = 1'b0;
      if (spur) begin
        ntt_done_i = 1'b1;
        ntt_poly_c_i = '1;
        spur = 1'b0;
      end
      if (rst_i) begin
        busy = 1'b0;
      end else if (busy) begin
        if (!hang && cnt == lat - 1) begin
          ntt_done_i = 1'b1;
          ntt_poly_c_i = wr_model(m, a, b);
          busy = 1'b0;
        end else begin
          cnt++;
        end
      end else if (ntt_run_o) begin
        busy = 1'b1;
        cnt = 0;
        m = ntt_mode_o;
        a = ntt_poly_a_o;
        b = ntt_poly_b_o;
      end
    end
  end

  initial begin
    int n;
    int rc;
    rst_i = 1'b1;
    req_i = '0;
    for (int i = 0; i < N; i++) begin
      mode_i[i] = NTT_a;
      poly_a_i[i] = mkpoly(i);
      poly_b_i[i] = mkpoly(i + 10);
    end
    step();
    step();
    check("rst_gnt", gnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_run", ntt_run_o, 0);
    check("rst_pc", fold(poly_c_o), 0);
    check("rst_mode", ntt_mode_o, NTT_a);
    check("rst_pa", fold(ntt_poly_a_o), 0);
    rst_i = 1'b0;
    step();

    // single request, 600-cycle wrapper
    lat = 600;
    rc = run_cnt;
    req_i = 3'b001;
    step();
    check("t1_gnt", gnt_o, 3'b001);
    check("t1_run", ntt_run_o, 1);
    req_i = '0;
    step();
    check("t1_run_off", ntt_run_o, 0);
    check("t1_opa", fold(ntt_poly_a_o), fold(mkpoly(0)));
    wait_done("t1_wait", 700, n);
    check("t1_lat", n, 600);
    check("t1_done", done_o, 3'b001);
    check("t1_err", err_o, 0);
    check("t1_gnt_hold", gnt_o, 3'b001);
    check("t1_pc", fold(poly_c_o), fold(wr_model(NTT_a, mkpoly(0), mkpoly(10))));
    step();
    check("t1_done_off", done_o, 0);
    check("t1_gnt_off", gnt_o, 0);
    check("t1_runs", run_cnt - rc, 1);

    // round-robin with all requesting, from fresh pointer
    lat = 20;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    req_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_run($sformatf("t2_run%0d", k), 60, n);
      check($sformatf("t2_gnt%0d", k), gnt_o, 3'b001 << (k % 3));
      wait_done($sformatf("t2_wait%0d", k), 60, n);
      check($sformatf("t2_done%0d", k), done_o, 3'b001 << (k % 3));
      if (k == 5) req_i = '0;
    end
    step();

    // requester 1 drops mid-operation; mode/operand changes ignored
    mode_i[2] = PWM_ab;
    req_i = 3'b010;
    wait_run("t3_run1", 10, n);
    check("t3_gnt1", gnt_o, 3'b010);
    step();
    step();
    req_i = 3'b100;
    mode_i[1] = INTT_a;
    poly_a_i[1] = mkpoly(99);
    step();
    check("t3_mode_hold", ntt_mode_o, NTT_a);
    check("t3_opa_hold", fold(ntt_poly_a_o), fold(mkpoly(1)));
    wait_done("t3_wait1", 60, n);
    check("t3_done1", done_o, 3'b010);
    check("t3_err1", err_o, 0);
    check("t3_pc1", fold(poly_c_o), fold(wr_model(NTT_a, mkpoly(1), mkpoly(11))));
    mode_i[1] = NTT_a;
    poly_a_i[1] = mkpoly(1);
    wait_run("t3_run2", 10, n);
    check("t3_gnt2", gnt_o, 3'b100);
    check("t3_mode2", ntt_mode_o, PWM_ab);
    wait_done("t3_wait2", 60, n);
    req_i = '0;
    check("t3_done2", done_o, 3'b100);
    check("t3_pc2", fold(poly_c_o), fold(wr_model(PWM_ab, mkpoly(2), mkpoly(12))));
    step();
    step();

    // unsupported mode from requester 2
    mode_i[2] = INTT_a;
    rc = run_cnt;
    req_i = 3'b100;
    step();
    check("t4_gnt", gnt_o, 3'b100);
    check("t4_run", ntt_run_o, 0);
    check("t4_done_early", done_o, 0);
    req_i = '0;
    step();
    check("t4_done", done_o, 3'b100);
    check("t4_err", err_o, 1);
    check("t4_pc", fold(poly_c_o), 0);
    step();
    check("t4_done_off", done_o, 0);
    check("t4_err_off", err_o, 0);
    check("t4_gnt_off", gnt_o, 0);
    check("t4_runs", run_cnt - rc, 0);
    mode_i[2] = PWM_ab;

    // stray wrapper done while idle
    spur = 1'b1;
    step();
    step();
    step();
    check("sp_done", done_o, 0);
    check("sp_gnt", gnt_o, 0);

    // reset while BUSY, then pointer back to N-1
    req_i = 3'b001;
    wait_run("t5_run", 10, n);
    check("t5_gnt", gnt_o, 3'b001);
    step();
    step();
    step();
    rst_i = 1'b1;
    req_i = '0;
    step();
    check("t5_gnt_rst", gnt_o, 0);
    check("t5_done_rst", done_o, 0);
    check("t5_run_rst", ntt_run_o, 0);
    rst_i = 1'b0;
    req_i = 3'b110;
    wait_run("t5_run2", 10, n);
    check("t5_gnt2", gnt_o, 3'b010);
    wait_done("t5_wait2", 60, n);
    req_i = '0;
    check("t5_done2", done_o, 3'b010);
    step();
    step();

`ifdef NTT_ARB_TIMEOUT_EN
    // wrapper never answers: watchdog fires 17 cycles after launch
    hang = 1'b1;
    req_i = 3'b001;
    wait_run("t6_run", 10, n);
    req_i = '0;
    wait_done("t6_wait", 40, n);
    check("t6_lat", n, 17);
    check("t6_done", done_o, 3'b001);
    check("t6_err", err_o, 1);
    check("t6_pc", fold(poly_c_o), 0);
    hang = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
`endif

    check("gnt_onehot", hot_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
